regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised successor to the 8x16 MIPS register file.
- 1 synchronous write port, 2 combinational read ports, hardwired-zero register 0.
- Adds: async active-low reset, a sequenced bulk-clear engine with busy/done handshake, and a registered write-error flag.
- Sits in the MIPS datapath between decode (read addresses) and writeback (write port).

Parameters:
- DATA_WIDTH, 16, register width in bits (>=1).
- ADDR_WIDTH, 3, register address width; depth DEPTH = 2**ADDR_WIDTH (localparam, >=2).
- RESET_INDEX, 1: 1 = on reset, register i loads i truncated/zero-extended to DATA_WIDTH; 0 = all registers reset to 0.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- RegWrite  input  1  write enable, sampled at posedge clk
- write_register  input  ADDR_WIDTH  write address
- write_data  input  DATA_WIDTH  write data
- read_register_1  input  ADDR_WIDTH  read address, port 1
- read_data_1  output  DATA_WIDTH  read data, port 1 (combinational)
- read_register_2  input  ADDR_WIDTH  read address, port 2
- read_data_2  output  DATA_WIDTH  read data, port 2 (combinational)
- clear_req  input  1  request bulk clear of registers 1..DEPTH-1
- busy  output  1  clear engine active
- clear_done  output  1  one-cycle pulse when clear completes
- wr_err  output  1  one-cycle registered pulse on a rejected write

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- While reset_n=0:
  - registers load per RESET_INDEX; register 0 always 0.
  - FSM goes to IDLE; clear counter = 1.
  - busy, clear_done, wr_err = 0.
  - Reset mid-clear aborts the clear immediately; no clear_done.
- Reads: read_data_N = registers[read_register_N], combinational. Address 0 always reads 0. Both ports may use the same address.
- Write, IDLE: at posedge clk, RegWrite=1 and write_register!=0 -> registers[write_register] <= write_data. Visible on reads the following cycle (no bypass unless the optional feature is compiled in).
- Write rejection: any of these causes no storage change and wr_err=1 for the next cycle.
  - RegWrite=1 with write_register==0.
  - RegWrite=1 while busy=1 (includes the cycle clear_req is accepted).
- RegWrite=0 never raises wr_err. No simulation $display messages.
- FSM states IDLE, CLEAR:
  - IDLE -> CLEAR: clear_req=1 at posedge; the counter is reset to 1.
  - busy = 1 whenever state==CLEAR (registered; asserted the cycle after acceptance).
  - CLEAR, each cycle: registers[counter] <= 0; counter increments by 1.
  - CLEAR -> IDLE: on the cycle counter==DEPTH-1, that register is cleared, state returns to IDLE and clear_done pulses for 1 cycle aligned with busy falling.
  - clear_req while in CLEAR is ignored (not queued).
  - clear_req on the same cycle the FSM returns to IDLE is ignored; the requester must reissue it.
- Clear duration: exactly DEPTH-1 cycles of busy=1.
- Reads during CLEAR return current contents: cleared entries read 0, uncleared entries keep their old value.
- Simultaneous clear_req and a valid RegWrite in IDLE: the clear is accepted, the write is rejected and wr_err pulses.
- Counter width: ADDR_WIDTH; it does not wrap because the state exits at DEPTH-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When RegWrite=1, write_register!=0, busy=0 and read_register_N==write_register, read_data_N = write_data in that same cycle. Forwarding is combinational and independent per port; reg 0 is never forwarded.
- Undefined: read_data_N shows the old contents until the cycle after the write edge.

Test Plan:
- Reset with RESET_INDEX=1, DEPTH=8, W=16 -> read reg 5 = 0x0005, reg 0 = 0x0000. With RESET_INDEX=0 -> all read 0. busy, clear_done, wr_err = 0.
- Write 0xBEEF to reg 3, then read both ports at address 3 -> 0xBEEF next cycle. Write 0x1234 to reg 0 -> reg 0 stays 0 and wr_err pulses exactly 1 cycle.
- Load regs 1..7 with 0xAAAA, pulse clear_req -> busy high for 7 cycles, clear_done pulses once on the last of them (when busy falls), all regs read 0. A RegWrite to reg 2 mid-clear -> wr_err pulses and reg 2 ends at 0.
- Assert reset_n=0 during cycle 3 of a clear -> outputs drop to 0 asynchronously, no clear_done, registers hold their reset values.
- Bypass: with REGFILE_BYPASS_EN, write 0x00FF to reg 4 while reading reg 4 -> read_data_1 = 0x00FF in the same cycle. Without the macro -> old value, 0x00FF the next cycle.
- Parameter sweep DATA_WIDTH=32, ADDR_WIDTH=5 -> clear takes 31 cycles. With RESET_INDEX=1, reg 31 resets to 0x0000001F.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised MIPS register file: 1 write / 2 read ports, zero register, sequenced bulk clear.
// Optional write-through forwarding on both read ports when REGFILE_BYPASS_EN is defined.
module regfile_param #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 3,
    parameter int RESET_INDEX = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] write_register,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_register_1,
    output logic [DATA_WIDTH-1:0] read_data_1,
    input  logic [ADDR_WIDTH-1:0] read_register_2,
    output logic [DATA_WIDTH-1:0] read_data_2,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  clear_done,
    output logic                  wr_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] counter;
    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  last_clear;
    logic                  accept_clear;
    logic                  write_ok;
    logic                  write_bad;

    assign last_clear   = (counter == ADDR_WIDTH'(DEPTH - 1));
    assign accept_clear = (state == IDLE) && clear_req;
    // A clear request in IDLE wins over a same-cycle write, so the write is rejected.
    assign write_ok     = RegWrite && (state == IDLE) && !clear_req && (write_register != '0);
    assign write_bad    = RegWrite && ((write_register == '0) || (state == CLEAR) || clear_req);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clear_req)  state_next = CLEAR;
            CLEAR:   if (last_clear) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        clear_done = 1'b0;
        if (state == CLEAR) begin
            busy       = 1'b1;
            clear_done = last_clear;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter <= ADDR_WIDTH'(1);
            wr_err  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (RESET_INDEX != 0) ? DATA_WIDTH'(i) : '0;
            end
        end else begin
            wr_err <= write_bad;
            if (accept_clear) begin
                counter <= ADDR_WIDTH'(1);
            end else if (state == CLEAR) begin
                regs[counter] <= '0;
                // Hold at the last index so the counter never wraps back to 0.
                if (!last_clear) begin
                    counter <= counter + ADDR_WIDTH'(1);
                end
            end
            if (write_ok) begin
                regs[write_register] <= write_data;
            end
        end
    end

    always_comb begin
        read_data_1 = (read_register_1 == '0) ? '0 : regs[read_register_1];
        read_data_2 = (read_register_2 == '0) ? '0 : regs[read_register_2];
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && (write_register != '0) && !busy) begin
            if (read_register_1 == write_register) read_data_1 = write_data;
            if (read_register_2 == write_register) read_data_2 = write_data;
        end
`else
`endif
    end

endmodule

// File: tb/tb_regfile_param.sv
// Randomized bench for regfile_param against an array-based reference model,
// plus wide (32x32) and zero-reset instances for the parameter corners.
module tb_regfile_param;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        RegWrite = 1'b0;
    logic [2:0]  write_register = '0;
    logic [15:0] write_data = '0;
    logic [2:0]  read_register_1 = '0;
    logic [2:0]  read_register_2 = '0;
    logic [15:0] read_data_1, read_data_2;
    logic        clear_req = 1'b0;
    logic        busy, clear_done, wr_err;

    logic        b_we = 1'b0, b_cr = 1'b0;
    logic [4:0]  b_wa = '0, b_ra1 = '0, b_ra2 = '0;
    logic [31:0] b_wd = '0, b_rd1, b_rd2;
    logic        b_busy, b_done, b_err;

    logic        z_we = 1'b0, z_cr = 1'b0;
    logic [2:0]  z_wa = '0, z_ra1 = '0, z_ra2 = '0;
    logic [15:0] z_wd = '0, z_rd1, z_rd2;
    logic        z_busy, z_done, z_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_regs [DEPTH];
    int          cycles_left;
    logic        m_err;
    int          busy_seen;
    int          done_seen;

    regfile_param dut (
        .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite),
        .write_register(write_register), .write_data(write_data),
        .read_register_1(read_register_1), .read_data_1(read_data_1),
        .read_register_2(read_register_2), .read_data_2(read_data_2),
        .clear_req(clear_req), .busy(busy), .clear_done(clear_done), .wr_err(wr_err)
    );

    regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RESET_INDEX(1)) dut_big (
        .clk(clk), .reset_n(reset_n), .RegWrite(b_we),
        .write_register(b_wa), .write_data(b_wd),
        .read_register_1(b_ra1), .read_data_1(b_rd1),
        .read_register_2(b_ra2), .read_data_2(b_rd2),
        .clear_req(b_cr), .busy(b_busy), .clear_done(b_done), .wr_err(b_err)
    );

    regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .RESET_INDEX(0)) dut_zero (
        .clk(clk), .reset_n(reset_n), .RegWrite(z_we),
        .write_register(z_wa), .write_data(z_wd),
        .read_register_1(z_ra1), .read_data_1(z_rd1),
        .read_register_2(z_ra2), .read_data_2(z_rd2),
        .clear_req(z_cr), .busy(z_busy), .clear_done(z_done), .wr_err(z_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_regs[i] = 16'(i);
        cycles_left = 0;
        m_err = 1'b0;
    endtask

    function automatic logic [15:0] exp_read(input logic [2:0] a);
        if (a == 3'd0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && write_register == a && cycles_left == 0) return write_data;
`endif
        return m_regs[a];
    endfunction

    // One clock: drive, check reads before the edge, step model, check flags after the edge.
    task automatic cycle(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic [2:0] a1, input logic [2:0] a2, input logic cr);
        logic bad;
        RegWrite = we; write_register = wa; write_data = wd;
        read_register_1 = a1; read_register_2 = a2; clear_req = cr;
        #1;
        check("rd1", {16'h0, read_data_1}, {16'h0, exp_read(a1)});
        check("rd2", {16'h0, read_data_2}, {16'h0, exp_read(a2)});
        bad = we && (wa == 3'd0 || cycles_left > 0 || cr);
        if (cycles_left > 0) begin
            m_regs[DEPTH - cycles_left] = 16'h0000;
            cycles_left--;
        end else if (cr) begin
            cycles_left = DEPTH - 1;
        end else if (we && wa != 3'd0) begin
            m_regs[wa] = wd;
        end
        m_err = bad;
        @(posedge clk);
        #1;
        check("busy", {31'h0, busy}, {31'h0, cycles_left > 0});
        check("clear_done", {31'h0, clear_done}, {31'h0, cycles_left == 1});
        check("wr_err", {31'h0, wr_err}, {31'h0, m_err});
        if (busy) busy_seen++;
        if (clear_done) done_seen++;
    endtask

    initial begin
        int cnt;
        int dn;
        model_reset();
        read_register_1 = 3'd5;
        read_register_2 = 3'd0;
        #12;
        check("rst_r5", {16'h0, read_data_1}, 32'h0000_0005);
        check("rst_r0", {16'h0, read_data_2}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, clear_done}, 32'h0);
        check("rst_err", {31'h0, wr_err}, 32'h0);
        @(posedge clk);
        #3 reset_n = 1'b1;

        cycle(1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3, 1'b0);
        cycle(1'b0, 3'd0, 16'h0, 3'd3, 3'd3, 1'b0);
        check("beef", {16'h0, read_data_2}, 32'h0000_BEEF);
        cycle(1'b1, 3'd0, 16'h1234, 3'd0, 3'd0, 1'b0);
        cycle(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
        cycle(1'b1, 3'd4, 16'h00FF, 3'd4, 3'd4, 1'b0);
        cycle(1'b0, 3'd0, 16'h0, 3'd4, 3'd0, 1'b0);

        for (int i = 1; i < DEPTH; i++) cycle(1'b1, 3'(i), 16'hAAAA, 3'(i), 3'd1, 1'b0);
        busy_seen = 0;
        done_seen = 0;
        cycle(1'b0, 3'd0, 16'h0, 3'd2, 3'd7, 1'b1);
        for (int k = 0; k < DEPTH - 1; k++)
            cycle(k == 2, 3'd2, 16'h5555, 3'($urandom_range(0, 7)), 3'd2, k == DEPTH - 2);
        check("clr_len", 32'(busy_seen), 32'(DEPTH - 1));
        check("clr_done_cnt", 32'(done_seen), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 3'd0, 16'h0, 3'(i), 3'(DEPTH - 1 - i), 1'b0);
            check("cleared", {16'h0, read_data_1}, 32'h0);
        end

        for (int n = 0; n < 400; n++)
            cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom_range(0, 24) == 0);
        for (int n = 0; n < DEPTH + 2; n++) cycle(1'b0, 3'd0, 16'h0, 3'(n), 3'd0, 1'b0);

        cycle(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1);
        cycle(1'b0, 3'd0, 16'h0, 3'd1, 3'd3, 1'b0);
        cycle(1'b1, 3'd5, 16'h7777, 3'd1, 3'd5, 1'b0);
        RegWrite = 1'b0;
        clear_req = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, clear_done}, 32'h0);
        check("abort_err", {31'h0, wr_err}, 32'h0);
        model_reset();
        @(posedge clk);
        #3 reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 3'd0, 16'h0, 3'(i), 3'(i), 1'b0);

        b_ra1 = 5'd31;
        b_ra2 = 5'd0;
        #1;
        check("big_r31", b_rd1, 32'h0000_001F);
        check("big_r0", b_rd2, 32'h0);
        b_cr = 1'b1;
        @(posedge clk);
        #1 b_cr = 1'b0;
        cnt = 0;
        dn = 0;
        for (int g = 0; g < 100 && b_busy; g++) begin
            cnt++;
            if (b_done) dn++;
            @(posedge clk);
            #1;
        end
        check("big_clr_len", 32'(cnt), 32'd31);
        check("big_done_cnt", 32'(dn), 32'd1);
        check("big_r31_clr", b_rd1, 32'h0);

        for (int i = 0; i < DEPTH; i++) begin
            z_ra1 = 3'(i);
            z_ra2 = 3'(DEPTH - 1 - i);
            #1;
            check("zero_rd1", {16'h0, z_rd1}, 32'h0);
            check("zero_rd2", {16'h0, z_rd2}, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
